// File: rtl/mem_rd_stream.sv
// Read-side stream adapter for the 1R1W memory wrapper.
// Turns the fixed-latency read port into valid/ready request and response streams.
module mem_rd_stream #(
   parameter int WIDTH_ADDR = 8,
   parameter int WIDTH_DATA = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [WIDTH_ADDR-1:0] req_addr,
   output logic                  mem_ren,
   output logic [WIDTH_ADDR-1:0] mem_raddr,
   input  logic [WIDTH_DATA-1:0] mem_dout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH_DATA-1:0] rsp_data,
   output logic                  idle
);

   localparam int BUF_DEPTH = RD_LATENCY + 2;
   localparam int CW        = $clog2(BUF_DEPTH + 1);
   localparam int PW        = $clog2(BUF_DEPTH);
   localparam logic [CW:0]   CREDITS  = (CW+1)'(BUF_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

   logic [RD_LATENCY-1:0] track;
   logic [RD_LATENCY-1:0] track_next;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         occ;
   logic [CW:0]           used;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [WIDTH_DATA-1:0] data_q [BUF_DEPTH];
   logic                  capture;
   logic                  pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CW'(track[i]);
      end
   end

   // Both streams transfer on a cycle where valid and ready are high together; valid
   // never depends on ready, and req_ready depends only on registered counts so a
   // consumer stall cannot ripple combinationally back to the requester.
   always_comb begin
      used       = {1'b0, inflight} + {1'b0, occ};
      req_ready  = !rst && (used < CREDITS);
      mem_ren    = req_valid && req_ready;
      mem_raddr  = req_addr;
      capture    = track[RD_LATENCY-1];
      rsp_valid  = !rst && (occ != '0);
      pop        = rsp_valid && rsp_ready;
      rsp_data   = data_q[rptr];
      idle       = rst || ((inflight == '0) && (occ == '0));
      track_next = track << 1;
      track_next[0] = mem_ren;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         track <= '0;
         occ   <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         track <= track_next;
         occ   <= occ + CW'(capture) - CW'(pop);
         if (capture) wptr <= next_ptr(wptr);
         if (pop)     rptr <= next_ptr(rptr);
      end
   end

   // Storage is left unreset; the tracking bits decide what is ever read out.
   always_ff @(posedge clk) begin
      if (capture) data_q[wptr] <= mem_dout;
   end

endmodule

// File: tb/tb_mem_rd_stream.sv
// Bench for mem_rd_stream: one instance per legal read latency, each compared
// every cycle against a queue-based model of outstanding reads.
module tb_mem_rd_stream;

   localparam int WA = 8;
   localparam int WD = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid [2];
   logic          req_ready [2];
   logic [WA-1:0] req_addr  [2];
   logic          mem_ren   [2];
   logic [WA-1:0] mem_raddr [2];
   logic [WD-1:0] mem_dout  [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [WD-1:0] rsp_data  [2];
   logic          idle      [2];

   logic [WD-1:0] mem [256];
   logic [WD-1:0] d1 [2];
   logic [WD-1:0] d2;

   logic [WD-1:0] exp_q0[$];
   logic [WD-1:0] exp_q1[$];
   int            rdy_q0[$];
   int            rdy_q1[$];
   logic          acc [2];
   logic          pop [2];
   logic [WD-1:0] acc_data [2];

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_rd_stream #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .RD_LATENCY(1)) u0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .mem_ren(mem_ren[0]), .mem_raddr(mem_raddr[0]), .mem_dout(mem_dout[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .idle(idle[0])
   );

   mem_rd_stream #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .RD_LATENCY(2)) u1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .mem_ren(mem_ren[1]), .mem_raddr(mem_raddr[1]), .mem_dout(mem_dout[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .idle(idle[1])
   );

   // Memory read pipelines; idle cycles drive junk so stale captures show up.
   always @(posedge clk) begin
      d1[0] <= mem_ren[0] ? mem[mem_raddr[0]] : WD'($urandom);
      d1[1] <= mem_ren[1] ? mem[mem_raddr[1]] : WD'($urandom);
      d2    <= d1[1];
   end
   assign mem_dout[0] = d1[0];
   assign mem_dout[1] = d2;

   function automatic int lat(int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic int depth(int k);
      return lat(k) + 2;
   endfunction

   function automatic int qsize(int k);
      return (k == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(int k);
      logic          e_ready, e_valid, e_idle;
      logic [WD-1:0] front;
      int            front_rdy;
      front     = '0;
      front_rdy = 0;
      if (qsize(k) > 0) begin
         front     = (k == 0) ? exp_q0[0] : exp_q1[0];
         front_rdy = (k == 0) ? rdy_q0[0] : rdy_q1[0];
      end
      e_ready     = !rst && (qsize(k) < depth(k));
      e_valid     = !rst && (qsize(k) > 0) && (front_rdy <= cyc);
      e_idle      = rst || (qsize(k) == 0);
      acc[k]      = req_valid[k] && e_ready;
      pop[k]      = e_valid && rsp_ready[k];
      acc_data[k] = mem[req_addr[k]];
      chk($sformatf("u%0d.req_ready@%0d", k, cyc), 32'(req_ready[k]), 32'(e_ready));
      chk($sformatf("u%0d.mem_ren@%0d", k, cyc), 32'(mem_ren[k]), 32'(acc[k]));
      chk($sformatf("u%0d.mem_raddr@%0d", k, cyc), 32'(mem_raddr[k]), 32'(req_addr[k]));
      chk($sformatf("u%0d.rsp_valid@%0d", k, cyc), 32'(rsp_valid[k]), 32'(e_valid));
      chk($sformatf("u%0d.idle@%0d", k, cyc), 32'(idle[k]), 32'(e_idle));
      if (e_valid) chk($sformatf("u%0d.rsp_data@%0d", k, cyc), 32'(rsp_data[k]), 32'(front));
   endtask

   task automatic update_model(int k);
      if (rst) begin
         if (k == 0) begin exp_q0.delete(); rdy_q0.delete(); end
         else        begin exp_q1.delete(); rdy_q1.delete(); end
      end else begin
         if (pop[k]) begin
            if (k == 0) begin void'(exp_q0.pop_front()); void'(rdy_q0.pop_front()); end
            else        begin void'(exp_q1.pop_front()); void'(rdy_q1.pop_front()); end
         end
         if (acc[k]) begin
            if (k == 0) begin exp_q0.push_back(acc_data[k]); rdy_q0.push_back(cyc + lat(k) + 1); end
            else        begin exp_q1.push_back(acc_data[k]); rdy_q1.push_back(cyc + lat(k) + 1); end
         end
      end
   endtask

   // One clock cycle: inputs were set at the preceding negedge.
   task automatic step();
      #1;
      for (int k = 0; k < 2; k++) check_cycle(k);
      chk($sformatf("u0.no_full_capture@%0d", cyc), 32'(u0.capture && (u0.occ == 3)), 32'd0);
      chk($sformatf("u1.no_full_capture@%0d", cyc), 32'(u1.capture && (u1.occ == 4)), 32'd0);
      @(posedge clk);
      for (int k = 0; k < 2; k++) update_model(k);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(int budget);
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         rsp_ready[k] = 1'b1;
      end
      for (int n = 0; n < budget && (exp_q0.size() + exp_q1.size()) > 0; n++) step();
      step();
   endtask

   initial begin
      int sent;
      logic [1:0] w0, r0;
      for (int i = 0; i < 256; i++) mem[i] = WD'($urandom);
      mem[5] = 8'hA5;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         rsp_ready[k] = 1'b1;
         req_addr[k]  = '0;
      end
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      // Single read on the latency-1 instance.
      req_valid[0] = 1'b1;
      req_addr[0]  = 8'd5;
      step();
      req_valid[0] = 1'b0;
      step();
      #1;
      chk("t1_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t1_rsp_data", 32'(rsp_data[0]), 32'hA5);
      step();
      #1;
      chk("t1_idle", 32'(idle[0]), 32'd1);
      step();

      // Streaming on the latency-2 instance.
      for (int i = 0; i < 16; i++) begin
         req_valid[1] = 1'b1;
         req_addr[1]  = WA'(i);
         step();
      end
      drain(50);

      // Backpressure on the latency-1 instance.
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_addr[0] = WA'($urandom_range(0, 255));
         step();
      end
      #1;
      chk("t3_ready_low", 32'(req_ready[0]), 32'd0);
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[0] = WA'($urandom_range(0, 255));
         step();
      end
      drain(50);

      // Random stalls through several pointer wraps.
      sent = 0;
      for (int n = 0; n < 300 && sent < 10; n++) begin
         req_valid[0] = 1'b1;
         req_addr[0]  = WA'($urandom_range(0, 255));
         rsp_ready[0] = 1'($urandom_range(0, 1));
         step();
         if (acc[0]) sent++;
      end
      chk("t4_sent", 32'(sent), 32'd10);
      drain(100);

      // Reset with two reads in flight and one buffered (latency-2 instance).
      rsp_ready[1] = 1'b0;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr[1] = WA'($urandom_range(0, 255));
         step();
      end
      req_valid[1] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_ready[1] = 1'b1;
      #1;
      chk("t5_idle_after_rst", 32'(idle[1]), 32'd1);
      chk("t5_valid_after_rst", 32'(rsp_valid[1]), 32'd0);
      for (int i = 0; i < 4; i++) step();
      req_valid[1] = 1'b1;
      req_addr[1]  = 8'd5;
      step();
      req_valid[1] = 1'b0;
      step();
      step();
      #1;
      chk("t5_nominal_valid", 32'(rsp_valid[1]), 32'd1);
      chk("t5_nominal_data", 32'(rsp_data[1]), 32'hA5);
      drain(50);

      // Simultaneous capture and pop with one entry buffered.
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid[0] = 1'b1;
         req_addr[0]  = WA'($urandom_range(0, 255));
         w0 = u0.wptr;
         r0 = u0.rptr;
         step();
         if (i >= 2) begin
            chk($sformatf("t6_occ_%0d", i), 32'(u0.occ), 32'd1);
            chk($sformatf("t6_wptr_%0d", i), 32'(u0.wptr), 32'((w0 == 2'd2) ? 2'd0 : w0 + 2'd1));
            chk($sformatf("t6_rptr_%0d", i), 32'(u0.rptr), 32'((r0 == 2'd2) ? 2'd0 : r0 + 2'd1));
         end
      end
      drain(50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
